morse_msg_sequencer: RTL and testbench

Letter-queue scheduler that drives the existing Morse FSM. The queue buffers up to DEPTH 3-bit letter codes (A–H) written from the switch/button front end. On a start request it feeds them one at a time to the FSM through its `ld_ltr`/`in_ltr` inputs, waits for each letter to finish, then inserts a fixed inter-letter gap. It sits between the debounced user-input logic and the Morse FSM, and owns the FSM's load interface exclusively.

---
 rtl/morse_pkg.sv | 22 ++
 rtl/morse_ltr_fifo.sv | 74 +++++++
 rtl/morse_msg_sequencer.sv | 129 ++++++++++++
 tb/tb_morse_msg_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - letter codes, FSM idle code and sequencer state encoding
package morse_pkg;

    localparam logic [2:0] A_IN = 3'b000;
    localparam logic [2:0] B_IN = 3'b001;
    localparam logic [2:0] C_IN = 3'b010;
    localparam logic [2:0] D_IN = 3'b011;
    localparam logic [2:0] E_IN = 3'b100;
    localparam logic [2:0] F_IN = 3'b101;
    localparam logic [2:0] G_IN = 3'b110;
    localparam logic [2:0] H_IN = 3'b111;

    localparam logic [4:0] FSM_IDLE = 5'h0;

    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'd0,
        SEQ_ISSUE     = 2'd1,
        SEQ_WAIT_DONE = 2'd2,
        SEQ_GAP       = 2'd3
    } seq_state_e;

endpackage

// File: rtl/morse_ltr_fifo.sv
// rtl/morse_ltr_fifo.sv - DEPTHx3 circular letter buffer with flush and offset read port
module morse_ltr_fifo #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [2:0]       push_data,
    input  logic             pop,
    input  logic [PTR_W-1:0] rd_ofs,
    output logic [2:0]       rd_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [2:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_q && !flush;
    assign pop_ok  = pop && !empty_q && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            if (pop_ok)  rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Flags are registered from next-state count so they stay Moore outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH[PTR_W:0]);
            empty_q  <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data = mem_q[rd_ptr_q + rd_ofs];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/morse_msg_sequencer.sv
// rtl/morse_msg_sequencer.sv - letter queue scheduler feeding the Morse FSM load port; MORSE_SEQ_LOOP_EN enables looped playback
module morse_msg_sequencer
    import morse_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 27
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [2:0]               wr_ltr,
    input  logic                     start,
    input  logic                     abort,
    input  logic [4:0]               fsm_state,
    output logic                     ld_ltr,
    output logic [2:0]               ltr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);

    seq_state_e       state_q;
    logic             ld_ltr_q, busy_q;
    logic [2:0]       ltr_q;
    logic [24:0]      gap_q;
    logic             fifo_push, fifo_pop;
    logic [PTR_W-1:0] rd_ofs;
    logic [2:0]       rd_data;

`ifdef MORSE_SEQ_LOOP_EN
    logic [PTR_W-1:0] play_q;
    logic [PTR_W:0]   play_inc;
    logic [PTR_W-1:0] play_next;

    // Play pointer is an offset from the oldest entry and wraps at the fill level.
    assign play_inc  = {1'b0, play_q} + {{PTR_W{1'b0}}, 1'b1};
    assign play_next = (play_inc == count) ? '0 : play_inc[PTR_W-1:0];
    assign fifo_push = wr_en && !abort && !busy_q;
    assign fifo_pop  = 1'b0;
    assign rd_ofs    = play_q;
`else
    assign fifo_push = wr_en && !abort;
    assign fifo_pop  = (state_q == SEQ_ISSUE) && (fsm_state != FSM_IDLE) && !abort;
    assign rd_ofs    = '0;
`endif

    morse_ltr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort),
        .push      (fifo_push),
        .push_data (wr_ltr),
        .pop       (fifo_pop),
        .rd_ofs    (rd_ofs),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEQ_IDLE;
            ld_ltr_q <= 1'b0;
            ltr_q    <= 3'b000;
            busy_q   <= 1'b0;
            gap_q    <= '0;
`ifdef MORSE_SEQ_LOOP_EN
            play_q   <= '0;
`endif
        end else if (abort) begin
            state_q  <= SEQ_IDLE;
            ld_ltr_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MORSE_SEQ_LOOP_EN
            play_q   <= '0;
`endif
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (start && !empty && fsm_state == FSM_IDLE) begin
                        state_q  <= SEQ_ISSUE;
                        ld_ltr_q <= 1'b1;
                        ltr_q    <= rd_data;
                        busy_q   <= 1'b1;
                    end
                end
                SEQ_ISSUE: begin
                    if (fsm_state != FSM_IDLE) begin
                        state_q  <= SEQ_WAIT_DONE;
                        ld_ltr_q <= 1'b0;
`ifdef MORSE_SEQ_LOOP_EN
                        play_q   <= play_next;
`endif
                    end
                end
                SEQ_WAIT_DONE: begin
                    if (fsm_state == FSM_IDLE) begin
                        state_q <= SEQ_GAP;
                        gap_q   <= 25'(GAP_CYCLES - 1);
                    end
                end
                SEQ_GAP: begin
                    if (gap_q == '0) begin
                        if (!empty) begin
                            state_q  <= SEQ_ISSUE;
                            ld_ltr_q <= 1'b1;
                            ltr_q    <= rd_data;
                        end else begin
                            state_q <= SEQ_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q - 25'd1;
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign ld_ltr = ld_ltr_q;
    assign ltr    = ltr_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// tb/tb_morse_msg_sequencer.sv - randomized bench with queue reference model and reactive Morse FSM model
module tb_morse_msg_sequencer;
    import morse_pkg::*;

    localparam int DEPTH = 8;
    localparam int GAP   = 27;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef MORSE_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk;
    logic          reset_n, wr_en, start, abort;
    logic [2:0]    wr_ltr;
    logic [4:0]    fsm_state;
    logic          ld_ltr, full, empty, busy;
    logic [2:0]    ltr;
    logic [CW-1:0] count;

    morse_msg_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_ltr    (wr_ltr),
        .start     (start),
        .abort     (abort),
        .fsm_state (fsm_state),
        .ld_ltr    (ld_ltr),
        .ltr       (ltr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [2:0] exp_q[$];
    int  play_idx = 0, rises = 0, ld_len = 0, ack_cyc = -1, ack_hold = 0, fsm_cnt = 0, hold_cfg = 20;
    bit  fsm_pend = 0, model_en = 1, prev_ld = 0, prev_busy = 0, rand_hold = 0;
    logic [2:0] last_ltr = 3'b000;

    // One clock: DUT edge, observe at negedge, update queue model, check, step FSM model.
    task automatic tick();
        bit do_push, do_pop;
        logic [2:0] exp_l;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (!reset_n || abort) begin
            exp_q.delete();
            play_idx = 0;
        end else begin
            do_pop  = !LOOP && prev_ld && !ld_ltr;
            do_push = wr_en && (exp_q.size() < DEPTH) && !(LOOP && prev_busy);
            if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(wr_ltr);
        end
        checks++;
        if (count !== CW'(exp_q.size()) || empty !== (exp_q.size() == 0) || full !== (exp_q.size() == DEPTH)) begin
            errors++;
            $display("FAIL occupancy cycle %0d: count=%0d empty=%0b full=%0b, expected count=%0d", cyc, count, empty, full, exp_q.size());
        end
        if (ld_ltr && !prev_ld) begin
            rises++;
            ld_len = 1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL letter cycle %0d: ld_ltr=1 ltr=%0d, expected no load (queue empty)", cyc, ltr);
            end else begin
                exp_l = exp_q[LOOP ? (play_idx % exp_q.size()) : 0];
                if (ltr !== exp_l) begin
                    errors++;
                    $display("FAIL letter cycle %0d: ltr=%0d expected %0d", cyc, ltr, exp_l);
                end
            end
            play_idx++;
            last_ltr = ltr;
            if (ack_cyc >= 0) begin
                checks++;
                if (cyc - ack_cyc != ack_hold + GAP + 1) begin
                    errors++;
                    $display("FAIL gap cycle %0d: ack-to-load=%0d expected %0d", cyc, cyc - ack_cyc, ack_hold + GAP + 1);
                end
            end
            ack_cyc = -1;
        end else if (ld_ltr) begin
            ld_len++;
        end else if (prev_ld && !abort) begin
            checks++;
            if (ld_len != 2) begin
                errors++;
                $display("FAIL pulse_width cycle %0d: ld_ltr high %0d cycles, expected 2", cyc, ld_len);
            end
        end
        if (fsm_cnt > 0) begin
            fsm_cnt--;
            if (fsm_cnt == 0) fsm_state = 5'h0;
        end else if (fsm_pend) begin
            fsm_pend  = 0;
            ack_hold  = rand_hold ? int'($urandom_range(1, 25)) : hold_cfg;
            fsm_cnt   = ack_hold;
            fsm_state = 5'($urandom_range(1, 31));
            ack_cyc   = cyc;
        end else if (model_en && ld_ltr && fsm_state == 5'h0) begin
            fsm_pend = 1;
        end
        prev_ld   = ld_ltr;
        prev_busy = busy;
    endtask

    task automatic push(input logic [2:0] l);
        wr_en = 1'b1; wr_ltr = l;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; ack_cyc = -1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((busy || fsm_state != 5'h0 || fsm_pend) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL run_idle timeout: busy=%0b fsm_state=%0d after %0d cycles, expected idle", busy, fsm_state, n);
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        while (fsm_state == 5'h0 && n < 10) begin tick(); n++; end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL ack timeout: fsm_state=%0d ld_ltr=%0b, expected FSM to accept", fsm_state, ld_ltr);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_en = 1'b0; wr_ltr = 3'b000; start = 1'b0; abort = 1'b0; fsm_state = 5'h0;
        tick(); tick();
        checks++;
        if (ld_ltr !== 1'b0 || ltr !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: ld_ltr=%0b ltr=%0d busy=%0b, expected 0 0 0", ld_ltr, ltr, busy);
        end
        checks++;
        if (count !== '0 || full !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: count=%0d full=%0b empty=%0b, expected 0 0 1", count, full, empty);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || ld_ltr !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: busy=%0b ld_ltr=%0b, expected 0 0", busy, ld_ltr);
        end
    endtask

    task automatic test_start_ignored();
        pulse_start();
        tick();
        checks++;
        if (ld_ltr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_empty: ld_ltr=%0b busy=%0b, expected 0 0", ld_ltr, busy);
        end
        push(3'($urandom_range(0, 7)));
        model_en = 0; fsm_state = 5'h3;
        pulse_start();
        tick();
        checks++;
        if (ld_ltr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_fsm_busy: ld_ltr=%0b busy=%0b, expected 0 0", ld_ltr, busy);
        end
        fsm_state = 5'h0; model_en = 1;
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_basic();
        int r0 = rises;
        hold_cfg = 20; rand_hold = 0;
        push(A_IN); push(C_IN); push(E_IN);
        pulse_start();
        checks++;
        if (ld_ltr !== 1'b1 || ltr !== A_IN || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: ld_ltr=%0b ltr=%0d busy=%0b, expected 1 0 1", ld_ltr, ltr, busy);
        end
        run_idle(400);
        checks++;
        if (rises - r0 != 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_run: loads=%0d busy=%0b, expected 3 0", rises - r0, busy);
        end
    endtask

    task automatic test_full();
        int r0 = rises;
        rand_hold = 1;
        for (int i = 0; i < 9; i++) push(3'($urandom_range(0, 7)));
        checks++;
        if (full !== 1'b1 || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL full_flag: full=%0b count=%0d, expected 1 %0d", full, count, DEPTH);
        end
        pulse_start();
        run_idle(1500);
        checks++;
        if (rises - r0 != DEPTH) begin
            errors++;
            $display("FAIL full_run: loads=%0d expected %0d", rises - r0, DEPTH);
        end
    endtask

    task automatic test_push_pop();
        int r0 = rises;
        rand_hold = 1;
        for (int i = 0; i < 4; i++) push(3'($urandom_range(0, 7)));
        pulse_start();
        wait_ack();
        wr_en = 1'b1; wr_ltr = B_IN;
        tick();
        wr_en = 1'b0;
        checks++;
        if (count !== CW'(4) || ld_ltr !== 1'b0) begin
            errors++;
            $display("FAIL push_pop: count=%0d ld_ltr=%0b, expected 4 0", count, ld_ltr);
        end
        run_idle(1000);
        checks++;
        if (last_ltr !== B_IN || rises - r0 != 5) begin
            errors++;
            $display("FAIL push_pop_order: last=%0d loads=%0d, expected 1 5", last_ltr, rises - r0);
        end
    endtask

    task automatic test_abort();
        int r0;
        hold_cfg = 20; rand_hold = 0;
        for (int i = 0; i < 4; i++) push(3'($urandom_range(0, 7)));
        pulse_start();
        wait_ack();
        tick(); tick(); tick();
        checks++;
        if (count !== CW'(3) || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: count=%0d busy=%0b, expected 3 1", count, busy);
        end
        abort = 1'b1; wr_en = 1'b1; wr_ltr = 3'($urandom_range(0, 7));
        tick();
        abort = 1'b0; wr_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== '0 || empty !== 1'b1 || ld_ltr !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%0b count=%0d empty=%0b ld_ltr=%0b, expected 0 0 1 0", busy, count, empty, ld_ltr);
        end
        r0 = rises;
        repeat (150) tick();
        checks++;
        if (rises != r0 || fsm_state !== 5'h0) begin
            errors++;
            $display("FAIL abort_quiet: loads=%0d fsm_state=%0d, expected 0 0", rises - r0, fsm_state);
        end
    endtask

    task automatic test_random();
        rand_hold = 1;
        for (int round = 0; round < 4; round++) begin
            int r0 = rises;
            int n = int'($urandom_range(1, DEPTH));
            int accepted = 0;
            int k = 0;
            for (int i = 0; i < n; i++) push(3'($urandom_range(0, 7)));
            pulse_start();
            while ((busy || fsm_state != 5'h0 || fsm_pend) && k < 4000) begin
                wr_en  = ld_ltr && ($urandom_range(0, 2) == 0);
                wr_ltr = 3'($urandom_range(0, 7));
                if (wr_en && exp_q.size() < DEPTH) accepted++;
                tick();
                wr_en = 1'b0;
                k++;
            end
            checks++;
            if (k >= 4000 || rises - r0 != n + accepted) begin
                errors++;
                $display("FAIL random_run %0d: loads=%0d expected %0d (cycles %0d)", round, rises - r0, n + accepted, k);
            end
        end
    endtask

    task automatic test_loop();
        int r0 = rises;
        int k = 0;
        rand_hold = 1;
        push(D_IN); push(H_IN);
        pulse_start();
        while (rises - r0 < 6 && k < 1500) begin
            wr_en  = (k == 30);
            wr_ltr = 3'($urandom_range(0, 7));
            tick();
            wr_en = 1'b0;
            k++;
        end
        checks++;
        if (k >= 1500 || last_ltr !== H_IN || count !== CW'(2)) begin
            errors++;
            $display("FAIL loop_run: loads=%0d last=%0d count=%0d, expected 6 7 2", rises - r0, last_ltr, count);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL loop_abort: busy=%0b count=%0d empty=%0b, expected 0 0 1", busy, count, empty);
        end
        r0 = rises;
        repeat (150) tick();
        checks++;
        if (rises != r0) begin
            errors++;
            $display("FAIL loop_quiet: loads=%0d expected 0", rises - r0);
        end
    endtask

    initial begin
        test_reset();
        test_start_ignored();
`ifdef MORSE_SEQ_LOOP_EN
        test_loop();
`else
        test_basic();
        test_full();
        test_push_pop();
        test_abort();
        test_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
